// File: rtl/bam_integrated.sv
// Registered 32x32 signed radix-4 Booth multiplier with enable-gated operand/product registers.
// Optional BAM_PIPE_EN macro adds a pipeline stage after first-level partial-product compression.
module bam_integrated (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Multiplicand,
    input  logic [31:0] Multiplier,
    input  logic        enableA,
    input  logic        enableB,
    input  logic        enableOut,
    input  logic        resetA,
    input  logic        resetB,
    input  logic        resetOut,
    output logic [63:0] Product
);

    logic [31:0] rega;
    logic [31:0] regb;
    logic [63:0] regp;
    logic [63:0] ae;
    logic [32:0] bx;
    logic [63:0] pp [16];
    logic [63:0] l1 [8];
    logic [63:0] l1s [8];
    logic [63:0] l2 [4];
    logic [63:0] prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rega <= '0;
        else if (resetA)  rega <= '0;
        else if (enableA) rega <= Multiplicand;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       regb <= '0;
        else if (resetB)  regb <= '0;
        else if (enableB) regb <= Multiplier;
    end

    assign ae = {{32{rega[31]}}, rega};
    assign bx = {regb, 1'b0};

    // Booth digit from triplet {b[2i+1], b[2i], b[2i-1]}
    always_comb begin
        pp = '{default: '0};
        for (int i = 0; i < 16; i++) begin
            unique case (bx[2*i +: 3])
                3'b001, 3'b010: pp[i] = ae << (2*i);
                3'b011:         pp[i] = ae << (2*i + 1);
                3'b100:         pp[i] = -(ae << (2*i + 1));
                3'b101, 3'b110: pp[i] = -(ae << (2*i));
                default:        pp[i] = '0;
            endcase
        end
    end

    always_comb begin
        l1 = '{default: '0};
        for (int j = 0; j < 8; j++)
            l1[j] = pp[2*j] + pp[2*j + 1];
    end

`ifdef BAM_PIPE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 8; j++) l1s[j] <= '0;
        end else begin
            for (int j = 0; j < 8; j++) l1s[j] <= l1[j];
        end
    end
`else
    always_comb l1s = l1;
`endif

    always_comb begin
        l2 = '{default: '0};
        for (int k = 0; k < 4; k++)
            l2[k] = l1s[2*k] + l1s[2*k + 1];
        prod = (l2[0] + l2[1]) + (l2[2] + l2[3]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         regp <= '0;
        else if (resetOut)  regp <= '0;
        else if (enableOut) regp <= prod;
    end

    assign Product = regp;

endmodule

// File: tb/tb_bam_integrated.sv
// Randomized and directed bench for bam_integrated against a plain-arithmetic model.
// Build with +define+BAM_PIPE_EN to check the pipelined variant.
module tb_bam_integrated;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Multiplicand;
    logic [31:0] Multiplier;
    logic        enableA, enableB, enableOut;
    logic        resetA, resetB, resetOut;
    logic [63:0] Product;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] ma, mb;
    logic [63:0] mp, mpipe;

    bam_integrated dut (
        .clk(clk), .rst_n(rst_n),
        .Multiplicand(Multiplicand), .Multiplier(Multiplier),
        .enableA(enableA), .enableB(enableB), .enableOut(enableOut),
        .resetA(resetA), .resetB(resetB), .resetOut(resetOut),
        .Product(Product)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic model_clear();
        ma = '0; mb = '0; mp = '0; mpipe = '0;
    endtask

    // One clock edge: drive inputs, advance the model, land 1 time unit after the edge
    task automatic cyc(input logic [31:0] a, input logic [31:0] b,
                       input logic ea, input logic eb, input logic eo,
                       input logic ra, input logic rb, input logic ro);
        logic [63:0] cur;
        Multiplicand = a; Multiplier = b;
        enableA = ea; enableB = eb; enableOut = eo;
        resetA = ra; resetB = rb; resetOut = ro;
        @(posedge clk);
        cur = smul(ma, mb);
`ifdef BAM_PIPE_EN
        if (ro) mp = '0; else if (eo) mp = mpipe;
`else
        if (ro) mp = '0; else if (eo) mp = cur;
`endif
        mpipe = cur;
        if (ra) ma = '0; else if (ea) ma = a;
        if (rb) mb = '0; else if (eb) mb = b;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(32'h1234, 32'h5678, 1, 1, 1, 0, 0, 0);
        model_clear();
        vectors++;
        if (Product !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", Product);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_latency();
        logic [63:0] e1;
        cyc(0, 0, 0, 0, 1, 1, 1, 1);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(6, 7, 1, 1, 1, 0, 0, 0);
        vectors++;
        if (Product !== 64'd0) begin
            errors++;
            $display("FAIL latency_n: got %h expected 0", Product);
        end
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
`ifdef BAM_PIPE_EN
        e1 = 64'd0;
`else
        e1 = 64'd42;
`endif
        vectors++;
        if (Product !== e1) begin
            errors++;
            $display("FAIL latency_n1: got %h expected %h", Product, e1);
        end
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        vectors++;
        if (Product !== 64'd42) begin
            errors++;
            $display("FAIL latency_n2: got %h expected 42", Product);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [11] = '{32'd5, -32'sd4, 32'd10, -32'sd50, 32'd1234, 32'd99,
                                 32'd0, 32'd32, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tb [11] = '{32'd6, -32'sd7, -32'sd4, 32'd5, 32'd0, 32'd1,
                                 32'd0, 32'd23, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [63:0] te [11] = '{64'd30, 64'd28, 64'hFFFF_FFFF_FFFF_FFD8, -64'sd250, 64'd0, 64'd99,
                                 64'd0, 64'd736, 64'h4000_0000_0000_0000,
                                 64'hC000_0000_8000_0000, 64'd1};
        for (int i = 0; i < 11; i++) begin
            cyc(ta[i], tb[i], 1, 1, 0, 0, 0, 0);
            for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
            vectors++;
            if (Product !== te[i] || Product !== mp) begin
                errors++;
                $display("FAIL directed_%0d: got %h expected %h (model %h)",
                         i, Product, te[i], mp);
            end
        end
    endtask

    task automatic test_hold();
        cyc(77, 88, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (Product !== 64'd1) begin
            errors++;
            $display("FAIL hold: got %h expected 1", Product);
        end
    endtask

    task automatic test_clear();
        cyc(0, 0, 0, 0, 1, 0, 0, 1);
        vectors++;
        if (Product !== 64'd0) begin
            errors++;
            $display("FAIL clear_out: got %h expected 0", Product);
        end
        cyc(7, 3, 1, 1, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        vectors++;
        if (Product !== 64'd0) begin
            errors++;
            $display("FAIL clear_a_wins: got %h expected 0", Product);
        end
        cyc(5, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        vectors++;
        if (Product !== 64'd15) begin
            errors++;
            $display("FAIL clear_b_kept: got %h expected 15", Product);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            cyc($urandom, $urandom, 1, 1, 1, 0, 0, 0);
            vectors++;
            if (Product !== mp) begin
                errors++;
                $display("FAIL back_to_back_%0d: got %h expected %h", i, Product, mp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            cyc(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0),
                $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 15) == 0);
            vectors++;
            if (Product !== mp) begin
                errors++;
                $display("FAIL random_%0d: got %h expected %h", i, Product, mp);
            end
        end
    endtask

    task automatic test_async_reset();
        cyc(32'd123456, 32'd789, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        vectors++;
        if (Product !== 64'd97406784) begin
            errors++;
            $display("FAIL pre_reset: got %h expected %h", Product, 64'd97406784);
        end
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        vectors++;
        if (Product !== 64'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", Product);
        end
        @(negedge clk) rst_n = 1'b1;
        cyc(3, -32'sd4, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        vectors++;
        if (Product !== -64'sd12) begin
            errors++;
            $display("FAIL post_reset: got %h expected %h", Product, -64'sd12);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        Multiplicand = '0; Multiplier = '0;
        enableA = 0; enableB = 0; enableOut = 0;
        resetA = 0; resetB = 0; resetOut = 0;
        model_clear();
        test_reset();
        test_latency();
        test_directed();
        test_hold();
        test_clear();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
